// File: rtl/mem_store_buffer.sv
// Store buffer between EX/MEM and a word-addressed data memory: queues stores,
// retires them in bubble cycles, and forwards buffered data to younger loads.
module mem_store_buffer #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         MemRead,
   input  logic                         MemWrite,
   input  logic [WIDTH-1:0]             Addr,
   input  logic [WIDTH-1:0]             WriteData,
   output logic [WIDTH-1:0]             ReadData,
   output logic                         Stall,
   output logic [WIDTH-1:0]             mem_A,
   output logic [WIDTH-1:0]             mem_WD,
   output logic                         mem_WE,
   input  logic [WIDTH-1:0]             mem_RD,
   output logic [$clog2(DEPTH+1)-1:0]   Count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [WIDTH-1:0] addr_q [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;

   logic             is_load, is_idle, not_empty, full, starved;
   logic             stall, drain, enq;
   logic             fwd_hit;
   logic [WIDTH-1:0] fwd_data;

   // Walk oldest to youngest so the last match found is the youngest store.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         int unsigned slot;
         slot = 32'(head_q) + k;
         if (slot >= DEPTH) slot = slot - DEPTH;
         if ((k < 32'(count_q)) && (addr_q[PW'(slot)] == Addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[PW'(slot)];
         end
      end
   end

   always_comb begin
      is_load   = MemRead & ~MemWrite;
      is_idle   = ~MemRead & ~MemWrite;
      not_empty = (count_q != '0);
      full      = (count_q == CW'(DEPTH));
      starved   = (starve_q == SW'(STARVE_LIMIT));

      // Full-store and starvation share one stall/drain when they coincide.
      stall = not_empty & ((MemWrite & full) | (starved & ~is_idle));
      drain = not_empty & (is_idle | stall);
      enq   = MemWrite & ~stall;

      head_d = head_q;
      if (drain) head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);

      tail_d = tail_q;
      if (enq) tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);

      count_d = count_q;
      if (drain)    count_d = count_q - CW'(1);
      else if (enq) count_d = count_q + CW'(1);

      starve_d = starve_q;
      if (drain || !not_empty) starve_d = '0;
      else if (!starved)       starve_d = starve_q + SW'(1);

      mem_A    = '0;
      mem_WD   = '0;
      mem_WE   = 1'b0;
      ReadData = '0;
      if (drain) begin
         mem_A  = addr_q[head_q];
         mem_WD = data_q[head_q];
         mem_WE = 1'b1;
      end else if (is_load) begin
         mem_A    = Addr;
         ReadData = fwd_hit ? fwd_data : mem_RD;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         starve_q <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         starve_q <= starve_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (enq) begin
         addr_q[tail_q] <= Addr;
         data_q[tail_q] <= WriteData;
      end
   end

   assign Stall = stall;
   assign Count = count_q;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: a queue-based reference model predicts
// each cycle's outputs; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_store_buffer;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [31:0] Addr = '0, WriteData = '0;
   logic [31:0] ReadData, mem_A, mem_WD, mem_RD;
   logic        Stall, mem_WE;
   logic [2:0]  Count;

   mem_store_buffer #(.WIDTH(32), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
      .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
      .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
      .Count(Count)
   );

   always #5 CLK = ~CLK;

   // Environment memory: 64 words, aliased on the low 6 address bits.
   logic [31:0] ram [64];
   bit          written [64];

   function automatic logic [31:0] dflt(input logic [5:0] i);
      return (i == 6'd20) ? 32'h77 : (32'hC0DE0000 | 32'(i));
   endfunction

   assign mem_RD = written[mem_A[5:0]] ? ram[mem_A[5:0]] : dflt(mem_A[5:0]);

   always @(posedge CLK) begin
      if (mem_WE) begin
         ram[mem_A[5:0]]     <= mem_WD;
         written[mem_A[5:0]] <= 1'b1;
      end
   end

   // Reference model
   typedef struct packed { logic [31:0] a; logic [31:0] d; } ent_t;
   typedef struct packed {
      logic        stall, we, chk_a, chk_zero, chk_rd;
      logic [31:0] a, wd, rd;
      int          cnt;
   } exp_t;

   ent_t        mq[$];
   int          starve = 0;
   logic [31:0] refmem [64];
   exp_t        exp_q[$];
   bit          last_stall = 0;
   logic        p_rd, p_wr;
   logic [31:0] p_a, p_d;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   task automatic cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      bit idle, ld, drain, stall;
      int pre;
      @(posedge CLK); #1;
      MemRead = rd; MemWrite = wr; Addr = a; WriteData = d;
      p_rd = rd; p_wr = wr; p_a = a; p_d = d;
      idle  = !rd && !wr;
      ld    = rd && !wr;
      pre   = mq.size();
      drain = (pre > 0) && (idle || (wr && pre == DEPTH) || (starve == LIMIT && !idle));
      stall = drain && !idle;
      e = '0;
      e.stall = stall;
      e.we    = drain;
      e.cnt   = pre;
      if (drain) begin
         e.a = mq[0].a; e.wd = mq[0].d; e.chk_a = 1;
      end else if (ld) begin
         e.a = a; e.chk_a = 1;
      end else if (idle) begin
         e.chk_zero = 1;
      end
      if (ld && !stall) begin
         e.rd = refmem[a[5:0]];
         foreach (mq[i]) if (mq[i].a == a) e.rd = mq[i].d;
         e.chk_rd = 1;
      end else if (wr) begin
         e.rd = '0; e.chk_rd = 1;
      end
      exp_q.push_back(e);
      if (drain) begin
         refmem[mq[0].a[5:0]] = mq[0].d;
         void'(mq.pop_front());
      end
      if (wr && !stall) mq.push_back('{a: a, d: d});
      starve = (drain || pre == 0) ? 0 : ((starve < LIMIT) ? starve + 1 : LIMIT);
      last_stall = stall;
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, '0);
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("stall", 32'(Stall), 32'(e.stall));
         chk("mem_we", 32'(mem_WE), 32'(e.we));
         chk("count", 32'(Count), e.cnt);
         if (e.chk_a) chk("mem_a", mem_A, e.a);
         if (e.we) chk("mem_wd", mem_WD, e.wd);
         if (e.chk_zero) begin
            chk("idle_a", mem_A, 32'h0);
            chk("idle_wd", mem_WD, 32'h0);
         end
         if (e.chk_rd) chk("readdata", ReadData, e.rd);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 64; i++) refmem[i] = dflt(6'(i));
      #12;
      chk("rst_count", 32'(Count), 0);
      chk("rst_stall", 32'(Stall), 0);
      chk("rst_we", 32'(mem_WE), 0);
      @(negedge CLK); RST = 1'b1;

      // Single store then drain
      cycle(0, 1, 32'd5, 32'hAAAA0001);
      idles(2);
      // Youngest-match forwarding and in-order drain
      cycle(0, 1, 32'd3, 32'h11);
      cycle(0, 1, 32'd3, 32'h22);
      cycle(1, 0, 32'd3, '0);
      idles(3);
      // Full buffer plus store
      for (int i = 1; i <= 4; i++) cycle(0, 1, 32'(i), 32'h100 + 32'(i));
      cycle(0, 1, 32'd9, 32'h909);
      cycle(0, 1, 32'd9, 32'h909);
      idles(DEPTH + 1);
      // Starvation forced drain
      cycle(0, 1, 32'd50, 32'h5050);
      for (int i = 0; i < 10; i++) cycle(1, 0, 32'd20, '0);
      idles(2);
      // Miss with two entries, full-width address compare
      cycle(0, 1, 32'd10, 32'hA0);
      cycle(1, 1, 32'd11, 32'hB0);
      cycle(1, 0, 32'd12, '0);
      cycle(1, 0, 32'h4A, '0);
      idles(DEPTH + 1);
      // Asynchronous reset mid-sequence with three pending stores
      for (int i = 0; i < 3; i++) cycle(0, 1, 32'd30 + 32'(i), 32'hDEAD0000 + 32'(i));
      @(negedge CLK); #1;
      RST = 1'b0;
      #1;
      chk("midrst_count", 32'(Count), 0);
      chk("midrst_stall", 32'(Stall), 0);
      MemRead = 0; MemWrite = 0;
      mq.delete();
      starve = 0;
      last_stall = 0;
      @(posedge CLK);
      @(negedge CLK); RST = 1'b1;
      idles(3);
      cycle(1, 0, 32'd30, '0);

      // Randomized traffic; a stalled request is held for the next cycle
      for (int n = 0; n < 400; n++) begin
         if (last_stall) begin
            cycle(p_rd, p_wr, p_a, p_d);
         end else begin
            int unsigned sel;
            logic [31:0] a;
            sel = $urandom_range(0, 99);
            a = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a = a + 32'h40;
            if (sel < 40)      cycle($urandom_range(0, 1) == 1, 1, a, $urandom);
            else if (sel < 82) cycle(1, 0, a, '0);
            else               cycle(0, 0, '0, '0);
         end
      end
      idles(DEPTH + 2);
      @(negedge CLK); #1;
      if (exp_q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
